power_mode_ctrl: RTL and testbench

POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

---
 rtl/power_mode_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_power_mode_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_mode_ctrl.sv
// power_mode_ctrl: push-button power sequencer with synchronised and
// debounced inputs, hold-to-power-on, idle auto-off and drive-mode enables.
// Ports:
//   sys_clk        system clock, all state changes on its rising edge
//   rst_n          reset, ACTIVE-HIGH despite the name, async assert
//   power_on_btn   raw power-on button (1 = pressed)
//   power_off_btn  raw power-off button (1 = pressed)
//   mode_sw[2:0]   raw mode switches: 001 manual, 010 semi, 100 auto
//   activity       level, 1 = drive command/throttle active this cycle
//   power_now      engine powered (registered)
//   manual_en, semi_en, auto_en  mode enables, at most one high
//   power_on_led   copy of power_now
//   mode_led[2:0]  {auto_en, semi_en, manual_en}

// Two-flop synchroniser followed by a tick-based debouncer.
// The debounced value follows the synchronised input only after the
// input has differed from it, unchanged, for DEB_MS consecutive ticks.
module pmc_debounce #(
   parameter int W      = 1,
   parameter int DEB_MS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic [W-1:0] raw,
   output logic [W-1:0] deb
);

   localparam int DM = (DEB_MS > 0) ? DEB_MS : 1;
   localparam int CW = (DM > 1) ? $clog2(DM) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DM - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [W-1:0]  sync1_q;
   logic [W-1:0]  sync2_q;
   logic [W-1:0]  last_q;
   logic [W-1:0]  deb_q;
   logic [W-1:0]  deb_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // A changed sample (last_q differs) restarts the window, so a
   // multi-bit input must hold one value for the whole window.
   always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if ((sync2_q == deb_q) || (sync2_q != last_q)) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q >= CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         last_q  <= '0;
         deb_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign deb = deb_q;

endmodule

module power_mode_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int DEB_MS  = 20,
   parameter int HOLD_MS = 1000,
   parameter int IDLE_MS = 10000
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       power_on_btn,
   input  logic       power_off_btn,
   input  logic [2:0] mode_sw,
   input  logic       activity,
   output logic       power_now,
   output logic       manual_en,
   output logic       semi_en,
   output logic       auto_en,
   output logic       power_on_led,
   output logic [2:0] mode_led
);

   localparam int TICK_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_MS + 1);
   localparam int IW = $clog2(IDLE_MS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_MS);
   localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

   typedef enum logic [1:0] {
      S_OFF,
      S_HOLD,
      S_ON
   } state_t;

   // The port keeps its historical name but is active-high.
   logic rst;
   assign rst = rst_n;

   logic [TW-1:0] tick_cnt_q;
   logic [TW-1:0] tick_cnt_d;
   logic          tick;

   logic          on_deb;
   logic          off_deb;
   logic [2:0]    mode_deb;

   state_t        state_q;
   state_t        state_d;
   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;
   logic [IW-1:0] idle_q;
   logic [IW-1:0] idle_d;
   logic [2:0]    mode_q;
   logic [2:0]    mode_d;
   logic          power_q;
   logic          power_d;
   logic [2:0]    en_q;
   logic [2:0]    en_d;

   // Only a single selected mode is meaningful; anything else disables.
   function automatic logic [2:0] mode_filter(input logic [2:0] m);
      logic [2:0] r;
      case (m)
         3'b001, 3'b010, 3'b100: r = m;
         default:                r = 3'b000;
      endcase
      return r;
   endfunction

   // 1 ms prescaler
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
   end

   pmc_debounce #(
      .W      (1),
      .DEB_MS (DEB_MS)
   ) u_deb_on (
      .clk  (sys_clk),
      .rst  (rst),
      .tick (tick),
      .raw  (power_on_btn),
      .deb  (on_deb)
   );

   pmc_debounce #(
      .W      (1),
      .DEB_MS (DEB_MS)
   ) u_deb_off (
      .clk  (sys_clk),
      .rst  (rst),
      .tick (tick),
      .raw  (power_off_btn),
      .deb  (off_deb)
   );

   pmc_debounce #(
      .W      (3),
      .DEB_MS (DEB_MS)
   ) u_deb_mode (
      .clk  (sys_clk),
      .rst  (rst),
      .tick (tick),
      .raw  (mode_sw),
      .deb  (mode_deb)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idle_d  = idle_q;
      mode_d  = mode_q;
      unique case (state_q)
         S_OFF: begin
            hold_d = '0;
            idle_d = '0;
            mode_d = '0;
            // both buttons together count as off
            if (on_deb && !off_deb) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            idle_d = '0;
            mode_d = '0;
            if (off_deb || !on_deb) begin
               state_d = S_OFF;
               hold_d  = '0;
            end else if (hold_q >= HOLD_MAX) begin
               state_d = S_ON;
               mode_d  = mode_filter(mode_deb);
            end else if (tick) begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         S_ON: begin
            hold_d = '0;
            if (off_deb || (idle_q >= IDLE_MAX)) begin
               state_d = S_OFF;
               idle_d  = '0;
               mode_d  = '0;
            end else begin
               mode_d = mode_filter(mode_deb);
               // a held on-button counts as presence, like activity
               if (activity || on_deb) begin
                  idle_d = '0;
               end else if (tick) begin
                  idle_d = idle_q + IDLE_ONE;
               end
            end
         end
         default: begin
            state_d = S_OFF;
            hold_d  = '0;
            idle_d  = '0;
            mode_d  = '0;
         end
      endcase
      power_d = (state_d == S_ON);
      en_d    = power_d ? mode_d : 3'b000;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         state_q    <= S_OFF;
         hold_q     <= '0;
         idle_q     <= '0;
         mode_q     <= '0;
         power_q    <= 1'b0;
         en_q       <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         idle_q     <= idle_d;
         mode_q     <= mode_d;
         power_q    <= power_d;
         en_q       <= en_d;
      end
   end

   assign power_now    = power_q;
   assign power_on_led = power_q;
   assign manual_en    = en_q[0];
   assign semi_en      = en_q[1];
   assign auto_en      = en_q[2];
   assign mode_led     = en_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// tb_power_mode_ctrl: random and directed stimulus for power_mode_ctrl,
// compared every millisecond against a millisecond-level behaviour model.

module tb_power_mode_ctrl;

   localparam int CLK_HZ  = 10_000;
   localparam int DEB_MS  = 2;
   localparam int HOLD_MS = 10;
   localparam int IDLE_MS = 20;

   localparam int P_OFF  = 0;
   localparam int P_HOLD = 1;
   localparam int P_ON   = 2;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       power_on_btn = 1'b0;
   logic       power_off_btn = 1'b0;
   logic       activity = 1'b0;
   logic [2:0] mode_sw = 3'b000;
   logic       power_now;
   logic       manual_en;
   logic       semi_en;
   logic       auto_en;
   logic       power_on_led;
   logic [2:0] mode_led;

   int errors = 0;
   int checks = 0;

   logic       s_pwr = 1'b0;
   logic [2:0] s_en = 3'b000;

   int         m_phase;
   int         m_hold;
   int         m_idle;
   logic [2:0] m_mode;
   logic [2:0] d_val [3];
   logic [2:0] d_prev [3];
   int         d_cnt [3];

   power_mode_ctrl #(
      .CLK_HZ  (CLK_HZ),
      .DEB_MS  (DEB_MS),
      .HOLD_MS (HOLD_MS),
      .IDLE_MS (IDLE_MS)
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .power_on_btn  (power_on_btn),
      .power_off_btn (power_off_btn),
      .mode_sw       (mode_sw),
      .activity      (activity),
      .power_now     (power_now),
      .manual_en     (manual_en),
      .semi_en       (semi_en),
      .auto_en       (auto_en),
      .power_on_led  (power_on_led),
      .mode_led      (mode_led)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_OFF;
      m_hold  = 0;
      m_idle  = 0;
      m_mode  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         d_val[i]  = 3'b000;
         d_prev[i] = 3'b000;
         d_cnt[i]  = 0;
      end
   endtask

   task automatic model_off();
      m_phase = P_OFF;
      m_hold  = 0;
      m_idle  = 0;
      m_mode  = 3'b000;
   endtask

   // one millisecond of a debouncer: follow after DEB_MS steady ms
   task automatic deb_step(input int i, input logic [2:0] raw);
      if (raw == d_val[i]) d_cnt[i] = 0;
      else if (raw != d_prev[i]) d_cnt[i] = 1;
      else d_cnt[i] = d_cnt[i] + 1;
      if (d_cnt[i] >= DEB_MS) begin
         d_val[i] = raw;
         d_cnt[i] = 0;
      end
      d_prev[i] = raw;
   endtask

   // advance the model by one millisecond with the given input levels
   task automatic model_tick(input logic on, input logic off,
                             input logic [2:0] md, input logic a);
      logic on_d;
      logic off_d;
      if (m_phase == P_HOLD && m_hold < HOLD_MS) m_hold = m_hold + 1;
      if (m_phase == P_ON) begin
         if (a || d_val[0][0]) m_idle = 0;
         else if (m_idle < IDLE_MS) m_idle = m_idle + 1;
      end
      deb_step(0, {2'b00, on});
      deb_step(1, {2'b00, off});
      deb_step(2, md);
      on_d  = d_val[0][0];
      off_d = d_val[1][0];
      case (m_phase)
         P_OFF: begin
            if (on_d && !off_d) begin
               m_phase = P_HOLD;
               m_hold  = 0;
            end
         end
         P_HOLD: begin
            if (off_d || !on_d) model_off();
            else if (m_hold >= HOLD_MS) begin
               m_phase = P_ON;
               m_idle  = 0;
            end
         end
         default: begin
            if (off_d || m_idle >= IDLE_MS) model_off();
            else if (on_d) m_idle = 0;
         end
      endcase
      if (m_phase == P_ON && $countones(d_val[2]) == 1) m_mode = d_val[2];
      else m_mode = 3'b000;
   endtask

   // one ms frame: check settled outputs, drive new inputs, step model
   task automatic frame(input logic on, input logic off,
                        input logic [2:0] md, input logic a);
      repeat (4) @(posedge sys_clk);
      #1;
      s_pwr = power_now;
      s_en  = {auto_en, semi_en, manual_en};
      chk("power_now", 8'(power_now), 8'(m_phase == P_ON));
      chk("power_led", 8'(power_on_led), 8'(m_phase == P_ON));
      chk("enables", 8'({auto_en, semi_en, manual_en}), 8'(m_mode));
      chk("mode_led", 8'(mode_led), 8'(m_mode));
      power_on_btn  = on;
      power_off_btn = off;
      mode_sw       = md;
      activity      = a;
      model_tick(on, off, md, a);
      repeat (6) @(posedge sys_clk);
   endtask

   task automatic frames(input int n, input logic on, input logic off,
                         input logic [2:0] md, input logic a);
      for (int k = 0; k < n; k++) frame(on, off, md, a);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b1;
      #1;
      chk("rst_power_now", 8'(power_now), 8'h00);
      chk("rst_enables", 8'({auto_en, semi_en, manual_en}), 8'h00);
      chk("rst_leds", 8'({power_on_led, mode_led}), 8'h00);
      power_on_btn  = 1'b0;
      power_off_btn = 1'b0;
      mode_sw       = 3'b000;
      activity      = 1'b0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b0;
      repeat (10) @(posedge sys_clk);
   endtask

   initial begin
      int lat;
      model_reset();
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b0;
      repeat (10) @(posedge sys_clk);

      frames(3, 1'b0, 1'b0, 3'b000, 1'b0);

      // hold-to-power-up, semi mode
      lat = -1;
      for (int j = 0; j < 15; j++) begin
         frame(1'b1, 1'b0, 3'b010, 1'b0);
         if (s_pwr && lat < 0) lat = j;
      end
      chk("power_up_ms_ok", 8'(lat >= 11 && lat <= 13), 8'h01);
      frames(3, 1'b0, 1'b0, 3'b010, 1'b1);
      chk("semi_en_on", 8'(s_en), 8'h02);

      // periodic activity keeps power
      for (int r = 0; r < 4; r++) begin
         frame(1'b0, 1'b0, 3'b010, 1'b1);
         frames(14, 1'b0, 1'b0, 3'b010, 1'b0);
      end
      chk("keep_alive", 8'(s_pwr), 8'h01);

      // idle timeout
      frame(1'b0, 1'b0, 3'b010, 1'b1);
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         frame(1'b0, 1'b0, 3'b010, 1'b0);
         if (!s_pwr) lat = k;
      end
      chk("idle_off_ms_ok", 8'(lat >= 19 && lat <= 21), 8'h01);

      // mode walk in ON
      frames(14, 1'b1, 1'b0, 3'b001, 1'b1);
      frames(3, 1'b0, 1'b0, 3'b001, 1'b1);
      chk("mode_manual", 8'(s_en), 8'h01);
      frames(4, 1'b0, 1'b0, 3'b011, 1'b1);
      chk("mode_invalid", 8'(s_en), 8'h00);
      frames(4, 1'b0, 1'b0, 3'b100, 1'b1);
      chk("mode_auto", 8'(s_en), 8'h04);
      frame(1'b0, 1'b0, 3'b010, 1'b1);
      frames(4, 1'b0, 1'b0, 3'b100, 1'b1);
      chk("mode_glitch", 8'(s_en), 8'h04);

      // both buttons in ON
      frames(4, 1'b1, 1'b1, 3'b100, 1'b1);
      chk("both_btn_off", 8'(s_pwr), 8'h00);
      frames(3, 1'b0, 1'b0, 3'b100, 1'b0);

      // short press never powers up
      frames(6, 1'b1, 1'b0, 3'b010, 1'b0);
      frames(15, 1'b0, 1'b0, 3'b010, 1'b0);
      chk("short_press", 8'(s_pwr), 8'h00);

      // reset mid-HOLD, then reset in ON
      frames(6, 1'b1, 1'b0, 3'b010, 1'b0);
      do_reset();
      frames(14, 1'b1, 1'b0, 3'b100, 1'b0);
      frames(2, 1'b0, 1'b0, 3'b100, 1'b1);
      chk("pre_reset_on", 8'(s_pwr), 8'h01);
      do_reset();
      frames(2, 1'b0, 1'b0, 3'b000, 1'b0);

      // random segments
      for (int s = 0; s < 40; s++) begin
         int len;
         logic on;
         logic off;
         logic [2:0] md;
         len = $urandom_range(1, 22);
         on  = ($urandom_range(0, 99) < 60);
         off = ($urandom_range(0, 99) < 12);
         md  = 3'($urandom_range(0, 7));
         for (int k = 0; k < len; k++) begin
            logic a;
            a = ($urandom_range(0, 99) < 25);
            frame(on, off, md, a);
         end
         if ($urandom_range(0, 19) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
